// File: rtl/training_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : training_sample_feeder
// Purpose  : Host-written sample buffer that streams samples, epoch by epoch,
//            to the neuron trainer until it converges or hits an epoch limit.
// Revision : 1.0  initial release
// ============================================================================
module training_sample_feeder #(
    parameter int ADDR_W     = 6,
    parameter int MAX_EPOCHS = 1000
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [6:0]        wrX1,
    input  logic [6:0]        wrX2,
    input  logic [1:0]        wrT,
    input  logic [ADDR_W:0]   numSamples,
    input  logic              go,
    input  logic              readyToGetData,
    input  logic              done,
    output logic              start,
    output logic [31:0]       nBus,
    output logic [6:0]        X1Bus,
    output logic [6:0]        X2Bus,
    output logic [1:0]        tBus,
    output logic              busy,
    output logic              finished,
    output logic              timedOut,
    output logic [15:0]       epochCount
);
    localparam int              DEPTH       = 2**ADDR_W;
    localparam logic [1:0]      S_IDLE      = 2'd0;
    localparam logic [1:0]      S_START     = 2'd1;
    localparam logic [1:0]      S_FEED      = 2'd2;
    localparam logic [1:0]      S_END       = 2'd3;
    localparam logic [ADDR_W:0] C_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ONE       = (ADDR_W+1)'(1);
    localparam logic [15:0]     C_EPOCH_SAT = 16'hFFFF;

    // Sample word layout: {x1[6:0], x2[6:0], t[1:0]}
    logic [15:0]       mem [DEPTH];

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] idx_q,       idx_d;
    logic [ADDR_W:0]   n_q,         n_d;
    logic [15:0]       sample_q,    sample_d;
    logic              finished_q,  finished_d;
    logic              timed_out_q, timed_out_d;
    logic [15:0]       epoch_q,     epoch_d;

    logic              go_ok;
    logic              last_idx;
    logic [15:0]       epoch_inc;

    always_ff @(posedge clk) begin
        if (wrEn && !busy) begin
            mem[wrAddr] <= {wrX1, wrX2, wrT};
        end
    end

    assign go_ok     = go && (numSamples != '0) && (numSamples <= C_DEPTH);
    assign last_idx  = ({1'b0, idx_q} == (n_q - C_ONE));
    assign epoch_inc = (epoch_q == C_EPOCH_SAT) ? epoch_q : epoch_q + 16'd1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            n_q         <= '0;
            sample_q    <= '0;
            finished_q  <= 1'b0;
            timed_out_q <= 1'b0;
            epoch_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            sample_q    <= sample_d;
            finished_q  <= finished_d;
            timed_out_q <= timed_out_d;
            epoch_q     <= epoch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        sample_d    = sample_q;
        finished_d  = finished_q;
        timed_out_d = timed_out_q;
        epoch_d     = epoch_q;
        case (state_q)
            S_IDLE: begin
                if (go_ok) begin
                    n_d         = numSamples;
                    idx_d       = '0;
                    finished_d  = 1'b0;
                    timed_out_d = 1'b0;
                    epoch_d     = '0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                sample_d = mem[idx_q];
                if (done) begin
                    finished_d = 1'b1;
                    state_d    = S_END;
                end else begin
                    state_d    = S_FEED;
                end
            end
            S_FEED: begin
                // done wins over the handshake: no advance on that edge
                if (done) begin
                    finished_d = 1'b1;
                    state_d    = S_END;
                end else if (readyToGetData) begin
                    if (last_idx) begin
                        idx_d   = '0;
                        epoch_d = epoch_inc;
                        if (32'(epoch_inc) == 32'(MAX_EPOCHS)) begin
                            timed_out_d = 1'b1;
                            state_d     = S_END;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                    sample_d = mem[idx_d];
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start = (state_q == S_START);
        busy  = (state_q != S_IDLE);
    end

    assign nBus       = {{(31-ADDR_W){1'b0}}, n_q};
    assign X1Bus      = sample_q[15:9];
    assign X2Bus      = sample_q[8:2];
    assign tBus       = sample_q[1:0];
    assign finished   = finished_q;
    assign timedOut   = timed_out_q;
    assign epochCount = epoch_q;

endmodule
`default_nettype wire

// File: tb/tb_training_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_training_sample_feeder
// Purpose  : Self-checking bench for training_sample_feeder (MAX_EPOCHS = 3).
// Revision : 1.0  initial release
// ============================================================================
module tb_training_sample_feeder;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int MAXE   = 3;

    logic              clk = 1'b0;
    logic              rstN;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [6:0]        wrX1, wrX2;
    logic [1:0]        wrT;
    logic [ADDR_W:0]   numSamples;
    logic              go, readyToGetData, done;
    logic              start, busy, finished, timedOut;
    logic [31:0]       nBus;
    logic [6:0]        X1Bus, X2Bus;
    logic [1:0]        tBus;
    logic [15:0]       epochCount;

    always #5 clk = ~clk;

    training_sample_feeder #(.ADDR_W(ADDR_W), .MAX_EPOCHS(MAXE)) dut (
        .clk(clk), .rstN(rstN), .wrEn(wrEn), .wrAddr(wrAddr), .wrX1(wrX1),
        .wrX2(wrX2), .wrT(wrT), .numSamples(numSamples), .go(go),
        .readyToGetData(readyToGetData), .done(done), .start(start),
        .nBus(nBus), .X1Bus(X1Bus), .X2Bus(X2Bus), .tBus(tBus), .busy(busy),
        .finished(finished), .timedOut(timedOut), .epochCount(epochCount)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: a run is described by how many samples were consumed;
    // position and epoch follow by division.
    logic [15:0] mem_m [DEPTH];
    int          m_phase;   // 0 idle, 1 launch, 2 streaming, 3 closing
    int          m_n, m_cons;
    bit          m_fin, m_to;
    logic [15:0] m_bus;

    function automatic int m_epochs();
        int e;
        e = (m_n == 0) ? 0 : (m_cons / m_n);
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_n = 0; m_cons = 0; m_fin = 0; m_to = 0; m_bus = '0;
    endtask

    task automatic model_edge();
        if (wrEn && m_phase == 0) mem_m[wrAddr] = {wrX1, wrX2, wrT};
        case (m_phase)
            0: if (go && numSamples >= 1 && int'(numSamples) <= DEPTH) begin
                m_n = int'(numSamples); m_cons = 0; m_fin = 0; m_to = 0; m_phase = 1;
            end
            1: begin
                m_bus = mem_m[0];
                if (done) begin m_fin = 1; m_phase = 3; end
                else m_phase = 2;
            end
            2: if (done) begin
                m_fin = 1; m_phase = 3;
            end else if (readyToGetData) begin
                m_cons++;
                m_bus = mem_m[m_cons % m_n];
                if (m_cons / m_n == MAXE) begin m_to = 1; m_phase = 3; end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        chk("start",      start,      (m_phase == 1));
        chk("busy",       busy,       (m_phase != 0));
        chk("finished",   finished,   m_fin);
        chk("timedOut",   timedOut,   m_to);
        chk("epochCount", epochCount, m_epochs());
        chk("nBus",       nBus,       m_n);
        chk("X1Bus",      X1Bus,      m_bus[15:9]);
        chk("X2Bus",      X2Bus,      m_bus[8:2]);
        chk("tBus",       tBus,       m_bus[1:0]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic write_sample(input int a, input int x1, input int x2, input int t);
        wrEn = 1; wrAddr = ADDR_W'(a); wrX1 = 7'(x1); wrX2 = 7'(x2); wrT = 2'(t);
        step();
        wrEn = 0;
    endtask

    task automatic run_go(input int cnt);
        numSamples = (ADDR_W+1)'(cnt); go = 1;
        step();
        go = 0;
    endtask

    typedef struct {
        bit rdy; bit dn;
        int x1; int x2; int t; int ep;
        bit fin; bit bsy;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 0, 10, 1, 1, 0, 0, 1};
        tbl[1] = '{1, 0, 20, 2, 3, 0, 0, 1};
        tbl[2] = '{1, 0, 30, 3, 1, 0, 0, 1};
        tbl[3] = '{1, 0, 40, 4, 3, 0, 0, 1};
        tbl[4] = '{1, 0, 10, 1, 1, 1, 0, 1};
        tbl[5] = '{1, 0, 20, 2, 3, 1, 0, 1};
        tbl[6] = '{1, 1, 20, 2, 3, 1, 1, 1};
        tbl[7] = '{0, 0, 20, 2, 3, 1, 1, 0};

        rstN = 0; wrEn = 0; wrAddr = '0; wrX1 = '0; wrX2 = '0; wrT = '0;
        numSamples = '0; go = 0; readyToGetData = 0; done = 0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        #12;
        check_model();
        rstN = 1;

        for (int i = 0; i < DEPTH; i++) write_sample(i, (i * 3) & 127, (i * 7 + 5) & 127, i & 3);
        write_sample(0, 10, 1, 1);
        write_sample(1, 20, 2, 3);
        write_sample(2, 30, 3, 1);
        write_sample(3, 40, 4, 3);

        // Basic run
        run_go(4);
        chk("go_busy", busy, 1'b1);
        chk("go_start", start, 1'b1);
        chk("go_nBus", nBus, 32'd4);
        for (int i = 0; i < 8; i++) begin
            readyToGetData = tbl[i].rdy; done = tbl[i].dn;
            step();
            chk("tbl_x1",  X1Bus,      tbl[i].x1);
            chk("tbl_x2",  X2Bus,      tbl[i].x2);
            chk("tbl_t",   tBus,       tbl[i].t);
            chk("tbl_ep",  epochCount, tbl[i].ep);
            chk("tbl_fin", finished,   tbl[i].fin);
            chk("tbl_bsy", busy,       tbl[i].bsy);
            chk("tbl_st",  start,      1'b0);
        end

        // Stall
        run_go(4);
        readyToGetData = 0; step();
        chk("stall_s0", X1Bus, 7'd10);
        readyToGetData = 1; step();
        chk("stall_s1a", X1Bus, 7'd20);
        readyToGetData = 0; step();
        chk("stall_s1b", X1Bus, 7'd20);
        step();
        chk("stall_s1c", X1Bus, 7'd20);
        readyToGetData = 1; step();
        chk("stall_s2", X1Bus, 7'd30);
        chk("stall_n", nBus, 32'd4);
        readyToGetData = 0; done = 1; step();
        done = 0; step();

        // Invalid counts, then the full-depth count
        run_go(0);
        chk("cnt0_busy", busy, 1'b0);
        chk("cnt0_start", start, 1'b0);
        run_go(65);
        chk("cnt65_busy", busy, 1'b0);
        chk("cnt65_start", start, 1'b0);
        step();
        chk("cnt65_start2", start, 1'b0);
        run_go(64);
        chk("cnt64_busy", busy, 1'b1);
        chk("cnt64_n", nBus, 32'd64);
        done = 1; step();
        chk("cnt64_fin", finished, 1'b1);
        done = 0; step();

        // Epoch limit
        run_go(2);
        readyToGetData = 1; step();
        for (int h = 1; h <= 6; h++) begin
            step();
            if (h == 5) chk("to_early", timedOut, 1'b0);
        end
        chk("to_flag", timedOut, 1'b1);
        chk("to_epoch", epochCount, 16'd3);
        chk("to_fin", finished, 1'b0);
        chk("to_x1", X1Bus, 7'd10);
        readyToGetData = 0; step();
        chk("to_idle", busy, 1'b0);
        chk("to_sticky", timedOut, 1'b1);

        // Write protection during a run, then done/ready priority
        run_go(4);
        readyToGetData = 1; step();
        wrEn = 1; wrAddr = '0; wrX1 = 7'd99; wrX2 = 7'd99; wrT = 2'd2;
        for (int h = 0; h < 4; h++) step();
        wrEn = 0;
        chk("prot_x1", X1Bus, 7'd10);
        chk("prot_x2", X2Bus, 7'd1);
        done = 1; step();
        chk("prio_x1", X1Bus, 7'd10);
        chk("prio_fin", finished, 1'b1);
        readyToGetData = 0; done = 0; step();

        // Asynchronous reset in the middle of streaming
        run_go(4);
        readyToGetData = 1; step(); step(); step();
        #2 rstN = 0;
        #1;
        model_reset();
        check_model();
        chk("rst_busy", busy, 1'b0);
        chk("rst_x1", X1Bus, 7'd0);
        readyToGetData = 0;
        #3 rstN = 1;
        run_go(4);
        readyToGetData = 1; step();
        chk("replay0", X1Bus, 7'd10);
        step(); chk("replay1", X1Bus, 7'd20);
        step(); chk("replay2", X1Bus, 7'd30);
        step(); chk("replay3", tBus, 2'd3);
        done = 1; step();
        done = 0; readyToGetData = 0; step();

        // Randomized traffic against the reference
        for (int c = 0; c < 1500; c++) begin
            wrEn   = ($urandom_range(0, 3) == 0);
            wrAddr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wrX1   = 7'($urandom); wrX2 = 7'($urandom); wrT = 2'($urandom);
            go     = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0:       numSamples = '0;
                1:       numSamples = (ADDR_W+1)'($urandom_range(64, 127));
                default: numSamples = (ADDR_W+1)'($urandom_range(1, 8));
            endcase
            readyToGetData = ($urandom_range(0, 3) != 0);
            done           = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
